monitor_word_tx: RTL and testbench
==================================

// Module: monitor_word_tx
// PURPOSE
//   UART word serializer on the monitor's TX path. Consumes one TX_BYTES*8-bit word
//   per valid/ready handshake from the run-to-UART FIFO drain logic in the 50 MHz domain.
//   Emits the word on tx_o as TX_BYTES consecutive 8N1 frames.
//   Frames go MS byte first; bits within a byte go LSB first. Result lines go to the host PC.
// PARAMETERS
//   CLK_FREQ   50_000_000  input clock frequency, Hz
//   BAUD       115_200     line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, must be >= 2)
//   TX_BYTES   4           bytes per accepted word (1..8)
// PORTS
//   clk_i       in   1              single clock (UART domain)
//   rst_i       in   1              asynchronous reset, active-high
//   tx_valid_i  in   1              word on tx_data_i is valid
//   tx_ready_o  out  1              block can accept a word this cycle
//   tx_data_i   in   TX_BYTES*8     word to transmit; sampled only at handshake
//   tx_o        out  1              serial line, idle high, registered
//   busy_o      out  1              high from handshake until the last stop bit completes
// BEHAVIOUR
//   - Interface: one clock, clk_i; asynchronous active-high reset, rst_i.
//   - Reset values (asynchronous): tx_o=1, tx_ready_o=1, busy_o=0, state=IDLE, all counters 0.
//   - Handshake: a word is accepted on the clk_i edge where tx_valid_i & tx_ready_o.
//     At that edge tx_data_i is latched into the shift register, and tx_ready_o and busy_o
//     are registered low and high. tx_valid_i while tx_ready_o=0 is ignored (no queueing).
//   - FSM states:
//       IDLE  -> START  on handshake
//       START -> DATA   after CLKS_PER_BIT cycles
//       DATA  -> PARITY after 8 bits, only with the macro
//       DATA  -> STOP   after 8 bits, without the macro
//       PARITY -> STOP  after CLKS_PER_BIT cycles
//       STOP  -> START  after CLKS_PER_BIT cycles if more bytes remain
//       STOP  -> IDLE   after CLKS_PER_BIT cycles on the last byte
//   - Timing: tx_o drives the start bit (0) from the cycle after the handshake.
//     Every bit lasts exactly CLKS_PER_BIT cycles. Stop bit = 1.
//     There is no idle gap between bytes of one word.
//   - Counters: baud counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1,
//     then wraps to 0 and advances the bit.
//     Bit counter counts 0..7; byte counter counts 0..TX_BYTES-1. No other wrap is legal.
//   - Byte order: byte k (k=0 first) = tx_data[TX_BYTES*8-1-8k -: 8].
//   - Word duration: TX_BYTES*FRAME*CLKS_PER_BIT cycles, FRAME = 10 (11 with parity).
//   - Back-to-back words:
//       the cycle after the final stop bit: IDLE, tx_ready_o=1, busy_o=0, tx_o=1;
//       a handshake in that cycle puts the next start bit on the following cycle;
//       this gives exactly 1 idle clk between words.
//   - Reset mid-word: tx_o returns to 1 immediately. The partial word is discarded
//     (no resume); the next handshake starts a fresh word at byte 0.
//   - tx_data_i changes after the handshake have no effect on the word in flight.
// CONFIGURATION
//   MONITOR_TX_PARITY_EN
//     defined: one EVEN parity bit (XOR of the 8 data bits) is inserted between
//       bit 7 and stop; FRAME=11.
//     undefined: no parity state or logic; FRAME=10.
// TESTING (CLK_FREQ=16, BAUD=1 -> CLKS_PER_BIT=16, TX_BYTES=4 unless stated)
//   1 Reset: assert rst_i mid-cycle -> tx_o=1, tx_ready_o=1, busy_o=0 with no clock edge.
//   2 Single word: send 32'hA5C3_0F81 -> start bit 1 cycle after handshake.
//     Bytes decode as A5,C3,0F,81, i.e. first data bits on line 1,0,1,0,0,1,0,1.
//     busy_o is high for 640 cycles.
//   3 Ignore while busy: pulse tx_valid_i with 32'hFFFF_FFFF at cycle 100 of a word
//     -> line shows only the original word; no extra frames.
//   4 Back-to-back: hold tx_valid_i with 32'h1234_5678 then 32'h9ABC_DEF0
//     -> 8 frames decode in order; exactly 1 idle-high clk between the two words.
//   5 Reset mid-word: rst_i during byte 1, data bit 3 -> tx_o=1 at once.
//     After release, send 32'h0000_00FF -> 00,00,00,FF decoded correctly.
//   6 Macro on: send 32'hA5C3_0F81 -> parity bits 0,0,0,0 (even popcounts).
//     Send 32'h0100_0000 -> byte 0 parity 1; word takes 704 cycles.

Source files
------------

// File: rtl/monitor_word_tx_if.sv
// Word handshake between the FIFO drain logic (master) and the UART word serializer (slave).
interface monitor_word_tx_if #(
  parameter int TX_BYTES = 4
) ();
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [TX_BYTES*8-1:0] tx_data_i;

  modport master (output tx_valid_i, output tx_data_i, input tx_ready_o);
  modport slave  (input tx_valid_i, input tx_data_i, output tx_ready_o);
endinterface

// File: rtl/monitor_word_tx.sv
// Serializes one TX_BYTES*8-bit word into TX_BYTES 8N1 frames, MS byte first, LSB-first bits.
// Optional feature: define MONITOR_TX_PARITY_EN to insert an even parity bit before stop.
module monitor_word_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int TX_BYTES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  monitor_word_tx_if.slave  bus,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W       = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
  localparam int W            = TX_BYTES * 8;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(TX_BYTES - 1);

`ifdef MONITOR_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_reg;
  logic [BAUD_W-1:0] baud_cnt_reg;
  logic [2:0]        bit_cnt_reg;
  logic [BYTE_W-1:0] byte_cnt_reg;
  logic [W-1:0]      word_reg;
  logic [7:0]        cur_byte;

  // The byte on the line always sits in the top of the word register.
  assign cur_byte = word_reg[W-1 -: 8];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      tx_o           <= 1'b1;
      bus.tx_ready_o <= 1'b1;
      busy_o         <= 1'b0;
      baud_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      byte_cnt_reg   <= '0;
      word_reg       <= '0;
    end else if (state_reg == IDLE) begin
      if (bus.tx_valid_i && bus.tx_ready_o) begin
        word_reg       <= bus.tx_data_i;
        state_reg      <= START;
        tx_o           <= 1'b0;
        bus.tx_ready_o <= 1'b0;
        busy_o         <= 1'b1;
        baud_cnt_reg   <= '0;
        bit_cnt_reg    <= '0;
        byte_cnt_reg   <= '0;
      end
    end else if (baud_cnt_reg != BAUD_LAST) begin
      baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
    end else begin
      baud_cnt_reg <= '0;
      case (state_reg)
        START: begin
          state_reg   <= DATA;
          bit_cnt_reg <= '0;
          tx_o        <= cur_byte[0];
        end
        DATA: begin
          if (bit_cnt_reg == 3'd7) begin
`ifdef MONITOR_TX_PARITY_EN
            state_reg <= PARITY;
            tx_o      <= ^cur_byte;
`else
            state_reg <= STOP;
            tx_o      <= 1'b1;
`endif
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            tx_o        <= cur_byte[bit_cnt_reg + 3'd1];
          end
        end
`ifdef MONITOR_TX_PARITY_EN
        PARITY: begin
          state_reg <= STOP;
          tx_o      <= 1'b1;
        end
`endif
        STOP: begin
          if (byte_cnt_reg == BYTE_LAST) begin
            // Ready comes back together with IDLE so a waiting word costs one idle clock.
            state_reg      <= IDLE;
            tx_o           <= 1'b1;
            bus.tx_ready_o <= 1'b1;
            busy_o         <= 1'b0;
            byte_cnt_reg   <= '0;
          end else begin
            state_reg    <= START;
            tx_o         <= 1'b0;
            byte_cnt_reg <= byte_cnt_reg + BYTE_W'(1);
            word_reg     <= word_reg << 8;
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_o      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_monitor_word_tx.sv
// Directed + random bench for monitor_word_tx: line waveform compared to a frame-level model.
module tb_monitor_word_tx;

  localparam int CPB = 16;
  localparam int NB  = 4;
`ifdef MONITOR_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int WORD_CYC = NB * FRAME * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx, busy;
  int   checks = 0;
  int   passes = 0;

  monitor_word_tx_if #(.TX_BYTES(NB)) bus ();

  monitor_word_tx #(.CLK_FREQ(16), .BAUD(1), .TX_BYTES(NB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .tx_o  (tx),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected line level c cycles after the handshake, from the frame layout alone.
  function automatic logic exp_bit(input logic [NB*8-1:0] w, input int c);
    int k   = c / (FRAME * CPB);
    int pos = (c % (FRAME * CPB)) / CPB;
    logic [7:0] b = 8'(w >> (8 * (NB - 1 - k)));
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef MONITOR_TX_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Wait for ready at a falling edge, then present the word across the next rising edge.
  task automatic hs(input logic [NB*8-1:0] w);
    int n = 0;
    while (bus.tx_ready_o !== 1'b1 && n < 4 * WORD_CYC) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_handshake", 64'(bus.tx_ready_o), 64'd1);
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = w;
    @(posedge clk);
    #1;
  endtask

  // Capture one word after its handshake edge and check it; optionally keep valid
  // high with the next word so it is taken in the idle cycle.
  task automatic watch(input logic [NB*8-1:0] w, input string tag, input int inject_at,
                       input bit hold, input logic [NB*8-1:0] next_w);
    logic cap [WORD_CYC];
    int   mism = 0;
    int   busy_hi = 0;
    logic [7:0] dec, expb;
    if (hold) begin
      bus.tx_valid_i = 1'b1;
      bus.tx_data_i  = next_w;
    end
    for (int c = 0; c < WORD_CYC; c++) begin
      @(negedge clk);
      cap[c] = tx;
      if (busy === 1'b1) busy_hi++;
      if (tx !== exp_bit(w, c)) mism++;
      if (!hold) begin
        if (c == inject_at) begin
          bus.tx_valid_i = 1'b1;
          bus.tx_data_i  = '1;
        end else begin
          bus.tx_valid_i = 1'b0;
          bus.tx_data_i  = $urandom;
        end
      end
    end
    chk({tag, "_wave_mismatches"}, 64'(mism), 64'd0);
    chk({tag, "_busy_cycles"}, 64'(busy_hi), 64'(WORD_CYC));
    for (int k = 0; k < NB; k++) begin
      expb = 8'(w >> (8 * (NB - 1 - k)));
      for (int j = 0; j < 8; j++) dec[j] = cap[(k * FRAME + 1 + j) * CPB + CPB / 2];
      chk($sformatf("%s_byte%0d", tag, k), 64'(dec), 64'(expb));
`ifdef MONITOR_TX_PARITY_EN
      chk($sformatf("%s_parity%0d", tag, k), 64'(cap[(k * FRAME + 9) * CPB + CPB / 2]),
          64'($countones(expb) % 2));
`endif
    end
    @(negedge clk);
    chk({tag, "_idle_tx"}, 64'(tx), 64'd1);
    chk({tag, "_idle_ready"}, 64'(bus.tx_ready_o), 64'd1);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    $display("word %h (%s) transmitted, %0d line mismatches", w, tag, mism);
  endtask

  initial begin
    logic [NB*8-1:0] rw;
    int quiet_bad;
    int target;
    bus.tx_valid_i = 1'b0;
    bus.tx_data_i  = '0;

    // Asynchronous reset before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("reset_tx", 64'(tx), 64'd1);
    chk("reset_ready", 64'(bus.tx_ready_o), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    hs(32'hA5C3_0F81);
    watch(32'hA5C3_0F81, "single", -1, 1'b0, '0);

    // A request while busy must be dropped, leaving the line quiet afterwards.
    @(negedge clk);
    hs(32'h1357_9BDF);
    watch(32'h1357_9BDF, "ignore", 100, 1'b0, '0);
    quiet_bad = 0;
    for (int c = 0; c < 2 * FRAME * CPB; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet_bad++;
    end
    chk("ignore_quiet_after", 64'(quiet_bad), 64'd0);

    hs(32'h1234_5678);
    watch(32'h1234_5678, "b2b_first", -1, 1'b1, 32'h9ABC_DEF0);
    watch(32'h9ABC_DEF0, "b2b_second", -1, 1'b0, '0);

    // Reset during byte 1, data bit 3.
    @(negedge clk);
    rw = $urandom;
    hs(rw);
    target = (1 * FRAME + 1 + 3) * CPB + 5;
    for (int c = 0; c <= target; c++) begin
      @(negedge clk);
      bus.tx_valid_i = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("midword_reset_tx", 64'(tx), 64'd1);
    chk("midword_reset_ready", 64'(bus.tx_ready_o), 64'd1);
    chk("midword_reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    hs(32'h0000_00FF);
    watch(32'h0000_00FF, "after_reset", -1, 1'b0, '0);

    for (int i = 0; i < 3; i++) begin
      rw = $urandom;
      @(negedge clk);
      hs(rw);
      watch(rw, $sformatf("random%0d", i), -1, 1'b0, '0);
    end

`ifdef MONITOR_TX_PARITY_EN
    @(negedge clk);
    hs(32'h0100_0000);
    watch(32'h0100_0000, "parity_odd_byte", -1, 1'b0, '0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
